// File: rtl/npu_pkg.sv
// -----------------------------------------------------------------------------
// npu_pkg
// Shared defaults for the psum drain path and the drain FSM state encoding.
//   DEF_DATA_WIDTH : signed accumulated-psum element width
//   DEF_H          : tile rows == output lanes
//   DEF_W          : tile columns == beats per tile
//   DEF_OUT_WIDTH  : signed requantized element width
//   DEF_SHIFT      : requant arithmetic right shift
// -----------------------------------------------------------------------------
package npu_pkg;

   localparam int DEF_DATA_WIDTH = 24;
   localparam int DEF_H          = 12;
   localparam int DEF_W          = 11;
   localparam int DEF_OUT_WIDTH  = 8;
   localparam int DEF_SHIFT      = 8;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

endpackage

// File: rtl/psum_requant.sv
// -----------------------------------------------------------------------------
// psum_requant
// One-element requantizer: round half up, arithmetic right shift, saturate.
//   x : signed [DATA_WIDTH-1:0] accumulated psum element
//   y : signed [OUT_WIDTH-1:0]  requantized, saturated element
// Purely combinational.
// -----------------------------------------------------------------------------
module psum_requant #(
   parameter int DATA_WIDTH = 24,
   parameter int OUT_WIDTH  = 8,
   parameter int SHIFT      = 8
) (
   input  logic signed [DATA_WIDTH-1:0] x,
   output logic signed [OUT_WIDTH-1:0]  y
);

   // One guard bit so adding the rounding constant cannot overflow.
   logic signed [DATA_WIDTH:0] rnd;
   logic signed [DATA_WIDTH:0] sum;
   logic signed [DATA_WIDTH:0] shifted;
   logic signed [DATA_WIDTH:0] max_v;
   logic signed [DATA_WIDTH:0] min_v;

   assign rnd     = {{DATA_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
   assign sum     = {x[DATA_WIDTH-1], x} + rnd;
   assign shifted = sum >>> SHIFT;

   assign max_v = {{(DATA_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
   assign min_v = {{(DATA_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

   always_comb begin
      y = shifted[OUT_WIDTH-1:0];
      if (shifted > max_v) begin
         y = max_v[OUT_WIDTH-1:0];
      end else if (shifted < min_v) begin
         y = min_v[OUT_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/psum_drain.sv
// -----------------------------------------------------------------------------
// psum_drain
// Captures a finished H x W psum tile, then streams it out one column per
// beat (lane i = row i), requantized to OUT_WIDTH bits.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   tile_valid : tile_data holds a finished tile
//   tile_data  : H x W signed psum tile
//   tile_ready : block can capture a tile this cycle (IDLE)
//   out_valid  : a column beat is presented (SEND)
//   out_ready  : downstream accepts the presented beat
//   out_data   : H requantized lanes of the current column
//   out_col    : column index of the current beat
//   out_last   : current beat is column W-1
// -----------------------------------------------------------------------------
module psum_drain
   import npu_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int H          = DEF_H,
   parameter int W          = DEF_W,
   parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
   parameter int SHIFT      = DEF_SHIFT
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        tile_valid,
   input  logic signed [DATA_WIDTH-1:0] tile_data [0:H-1][0:W-1],
   output logic                        tile_ready,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [OUT_WIDTH-1:0] out_data [0:H-1],
   output logic [3:0]                  out_col,
   output logic                        out_last
);

   localparam int         CW       = (W > 1) ? $clog2(W) : 1;
   localparam logic [3:0] LAST_COL = 4'(W - 1);

   state_t     state;
   state_t     state_next;
   logic [3:0] col;
   logic       capture;
   logic       xfer;

   logic signed [DATA_WIDTH-1:0] buffer [0:H-1][0:W-1];
   logic signed [DATA_WIDTH-1:0] elem   [0:H-1];
   logic [CW-1:0]                col_idx;

   // Handshakes use the reset-gated outputs, so nothing fires during rst.
   assign capture = tile_valid && tile_ready;
   assign xfer    = out_valid && out_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (capture) state_next = SEND;
         SEND: if (xfer && (col == LAST_COL)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic; outputs are forced quiet while rst is held.
   always_comb begin
      tile_ready = !rst && (state == IDLE);
      out_valid  = !rst && (state == SEND);
      out_col    = rst ? '0 : col;
      out_last   = out_valid && (col == LAST_COL);
   end

   // Column counter
   always_ff @(posedge clk) begin
      if (rst) begin
         col <= '0;
      end else if (capture) begin
         col <= '0;
      end else if (xfer && (col != LAST_COL)) begin
         col <= col + 4'd1;
      end
   end

   // Tile buffer: deliberately not reset, only written on the capture edge.
   always_ff @(posedge clk) begin
      if (capture) begin
         buffer <= tile_data;
      end
   end

   assign col_idx = col[CW-1:0];

   always_comb begin
      for (int unsigned i = 0; i < H; i++) begin
         elem[i] = buffer[i][col_idx];
      end
   end

   for (genvar i = 0; i < H; i++) begin : g_lane
      psum_requant #(
         .DATA_WIDTH (DATA_WIDTH),
         .OUT_WIDTH  (OUT_WIDTH),
         .SHIFT      (SHIFT)
      ) u_requant (
         .x (elem[i]),
         .y (out_data[i])
      );
   end

endmodule

// File: tb/tb_psum_drain.sv
// -----------------------------------------------------------------------------
// tb_psum_drain
// Directed self-checking bench for psum_drain with default parameters.
// -----------------------------------------------------------------------------
module tb_psum_drain;

   logic                clk = 1'b0;
   logic                rst;
   logic                tile_valid;
   logic signed [23:0]  tile [0:11][0:10];
   logic                tile_ready;
   logic                out_valid;
   logic                out_ready;
   logic signed [7:0]   od [0:11];
   logic [3:0]          out_col;
   logic                out_last;

   int tests = 0;
   int fails = 0;

   psum_drain dut (
      .clk        (clk),
      .rst        (rst),
      .tile_valid (tile_valid),
      .tile_data  (tile),
      .tile_ready (tile_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (od),
      .out_col    (out_col),
      .out_last   (out_last)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expected requantized lane value for the tile patterns below.
   function automatic int ev(input int kind, input int i, input int j);
      case (kind)
         0:       return i + j;
         1:       return 2 * j - i;
         default: return i + 2 * j;
      endcase
   endfunction

   // Pattern 256*v gives exactly v after round-half-up >>> 8.
   task automatic fill(input int kind);
      for (int i = 0; i < 12; i++)
         for (int j = 0; j < 11; j++)
            tile[i][j] = 24'(256 * ev(kind, i, j));
   endtask

   task automatic scramble();
      for (int i = 0; i < 12; i++)
         for (int j = 0; j < 11; j++)
            tile[i][j] = 24'($urandom);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expects to be entered 1 time unit after an edge, out_ready already high.
   task automatic drain(input int kind, input int n);
      for (int j = 0; j < n; j++) begin
         #1;
         chk($sformatf("valid[%0d]", j), out_valid, 1);
         chk($sformatf("col[%0d]", j), out_col, j);
         chk($sformatf("last[%0d]", j), out_last, (j == 10) ? 1 : 0);
         chk($sformatf("tready_busy[%0d]", j), tile_ready, 0);
         for (int i = 0; i < 12; i++)
            chk($sformatf("data[%0d][%0d]", i, j), od[i], ev(kind, i, j));
         tick();
      end
   endtask

   initial begin
      int xfers;
      int rvals [0:4];
      int rexp  [0:4];
      rvals = '{127, 128, 40000, -300, -40000};
      rexp  = '{0, 1, 127, -1, -128};

      rst = 1'b1; tile_valid = 1'b0; out_ready = 1'b0;
      scramble();

      // Reset held two cycles
      for (int c = 0; c < 2; c++) begin
         tick();
         #1;
         chk("rst_valid", out_valid, 0);
         chk("rst_tready", tile_ready, 0);
         chk("rst_col", out_col, 0);
         chk("rst_last", out_last, 0);
      end
      tick();
      rst = 1'b0;
      #1;
      chk("post_rst_tready", tile_ready, 1);
      chk("post_rst_valid", out_valid, 0);
      tick();

      // Nominal tile, tile_data disturbed after capture
      fill(0); tile_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("nom_tready", tile_ready, 1);
      tick();
      tile_valid = 1'b0; scramble();
      drain(0, 11);
      #1;
      chk("nom_done_tready", tile_ready, 1);
      chk("nom_done_valid", out_valid, 0);
      tick();

      // Rounding / saturation in column 0
      for (int i = 0; i < 12; i++)
         for (int j = 0; j < 11; j++)
            tile[i][j] = '0;
      for (int k = 0; k < 5; k++) tile[k][0] = 24'(rvals[k]);
      tile_valid = 1'b1;
      tick();
      tile_valid = 1'b0;
      #1;
      chk("rq_col", out_col, 0);
      for (int k = 0; k < 5; k++)
         chk($sformatf("rq[%0d]", k), od[k], rexp[k]);
      for (int c = 0; c < 11; c++) tick();
      chk("rq_done_valid", out_valid, 0);

      // Backpressure pattern 1,0,0,1
      fill(1); tile_valid = 1'b1;
      tick();
      tile_valid = 1'b0; scramble();
      xfers = 0;
      for (int c = 0; c < 60 && xfers < 11; c++) begin
         out_ready = ((c % 4) == 0) || ((c % 4) == 3);
         #1;
         chk($sformatf("bp_valid[%0d]", c), out_valid, 1);
         chk($sformatf("bp_col[%0d]", c), out_col, xfers);
         chk($sformatf("bp_last[%0d]", c), out_last, (xfers == 10) ? 1 : 0);
         chk($sformatf("bp_d0[%0d]", c), od[0], ev(1, 0, xfers));
         chk($sformatf("bp_d11[%0d]", c), od[11], ev(1, 11, xfers));
         if (out_ready) xfers++;
         tick();
      end
      chk("bp_xfers", xfers, 11);
      #1;
      chk("bp_done_valid", out_valid, 0);
      out_ready = 1'b1;
      tick();

      // Back-to-back: tile_valid held through the first tile's last beat
      fill(0); tile_valid = 1'b1;
      tick();
      fill(2);
      drain(0, 11);
      #1;
      chk("b2b_bubble_valid", out_valid, 0);
      chk("b2b_bubble_tready", tile_ready, 1);
      tick();
      tile_valid = 1'b0; scramble();
      drain(2, 11);
      #1;
      chk("b2b_done_valid", out_valid, 0);
      tick();

      // Reset in the middle of a tile
      fill(0); tile_valid = 1'b1;
      tick();
      tile_valid = 1'b0;
      drain(0, 5);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_col", out_col, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("mid_after_valid", out_valid, 0);
      chk("mid_after_tready", tile_ready, 1);
      fill(1); tile_valid = 1'b1;
      tick();
      tile_valid = 1'b0; scramble();
      drain(1, 11);
      #1;
      chk("mid_done_valid", out_valid, 0);
      chk("mid_done_tready", tile_ready, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/psum_drain.md
PSUM_DRAIN -- requirements
Module: psum_drain

Interface
REQ-001 Parameter DATA_WIDTH, default 24, SHALL set the signed accumulated-psum element width.
REQ-002 Parameter H, default 12, SHALL set the tile rows, which equal the output lanes.
REQ-003 Parameter W, default 11, SHALL set the tile columns, which equal the output beats per tile.
REQ-004 Parameter OUT_WIDTH, default 8, SHALL set the signed requantized element width.
REQ-005 Parameter SHIFT, default 8, SHALL set the requant arithmetic right shift; legal range is 1..DATA_WIDTH-1.
REQ-006 Port clk, input, 1 bit, SHALL be the single clock; all logic is rising-edge.
REQ-007 Port rst, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-008 Port tile_valid, input, 1 bit, SHALL flag that tile_data holds a finished, ReLU'd psum tile.
REQ-009 Port tile_data, input, signed [DATA_WIDTH-1:0] [0:H-1][0:W-1], SHALL be the tile payload.
REQ-010 Port tile_ready, output, 1 bit, SHALL indicate the block can capture a tile this cycle.
REQ-011 Port out_valid, output, 1 bit, SHALL flag that a column beat is presented.
REQ-012 Port out_ready, input, 1 bit, SHALL be downstream acceptance of the presented beat.
REQ-013 Port out_data, output, signed [OUT_WIDTH-1:0] [0:H-1], SHALL carry the requantized column, with lane i equal to row i.
REQ-014 Port out_col, output, 4 bits, SHALL carry the column index of the current beat.
REQ-015 Port out_last, output, 1 bit, SHALL be high on the beat where out_col equals W-1.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and SEND.
REQ-017 In IDLE, tile_ready SHALL be 1 and out_valid SHALL be 0.
REQ-018 In SEND, tile_ready SHALL be 0 and out_valid SHALL be 1.
REQ-019 A tile SHALL be captured into an internal H x W buffer when tile_valid and tile_ready are both high; on that edge col is set to 0 and the state moves to SEND.
REQ-020 The first beat SHALL appear in the cycle after capture (latency 1).
REQ-021 A beat SHALL transfer when out_valid and out_ready are both high; on transfer, col increments, or, if col equals W-1, the state returns to IDLE.
REQ-022 While out_valid is high and out_ready is low, out_data, out_col and out_last SHALL hold stable.
REQ-023 Requant per element SHALL be computed in DATA_WIDTH+1 bits as r = (x + 2^(SHIFT-1)) >>> SHIFT, rounding half up with an arithmetic shift.
REQ-024 The requant result SHALL saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-025 out_data SHALL be driven by the requant of buffer[i][col]; it may be combinational from the registered buffer and col.
REQ-026 When the last beat transfers and tile_valid is high in the same cycle, the new tile SHALL NOT be captured that cycle; it is captured in the next, IDLE cycle, giving a one-cycle bubble.
REQ-027 tile_data SHALL be ignored outside the capture edge; later changes to it do not affect beats already being sent.
REQ-028 out_col SHALL never exceed W-1; no beat is dropped or duplicated.

Reset
REQ-029 While rst is high: state SHALL be IDLE, out_valid 0, tile_ready 0, out_col 0, out_last 0.
REQ-030 In the first cycle after rst deasserts, tile_ready SHALL be 1.
REQ-031 Reset mid-SEND SHALL abort the tile; the next captured tile starts at col 0.
REQ-032 The tile buffer SHALL NOT be reset; its contents are don't-care until the next capture.

Structure
REQ-033 Shared package npu_pkg SHALL hold the DATA_WIDTH, H, W, OUT_WIDTH and SHIFT defaults and the state enum {IDLE, SEND}.
REQ-034 One combinational sub-module, psum_requant (one element: round, shift, saturate), SHALL be instantiated H times.

Verification
REQ-035 Reset: hold rst high for 2 cycles, then release -> out_valid=0 throughout, and tile_ready=1 in the first cycle after release.
REQ-036 Nominal: send a tile with x[i][j]=256*(i+j), SHIFT=8, out_ready=1, accepted at cycle t -> beats occur at t+1..t+11, out_data[i]=i+out_col, out_last only at col 10, tile_ready=1 again at t+12.
REQ-037 Rounding/saturation: inputs 127, 128, 40000, -300, -40000 -> outputs 0, 1, 127, -1, -128 respectively.
REQ-038 Backpressure: drive out_ready with pattern 1,0,0,1 repeating -> outputs stable during stalls, exactly 11 transfers with col 0..10 in order.
REQ-039 Back-to-back: hold tile_valid high with a second tile -> the second tile is captured the cycle after the first tile's last transfer, and its first beat follows one cycle later.
REQ-040 Mid-op reset: assert rst at col 5 -> out_valid=0 the next cycle; the next tile is sent from col 0 with correct data.
